// File: rtl/uart_tx_fifo_if.sv
// Core-side bus of the buffered UART transmitter: decoder strobe, register
// select, store/load data, plus the serial line and interrupt it returns.
interface uart_tx_fifo_if;
  logic        we;
  logic [1:0]  reg_sel;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;
  logic        irq;

  modport master (output we, reg_sel, wd, input rd, tx, irq);
  modport slave  (input we, reg_sel, wd, output rd, tx, irq);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer, status/control
// registers on a combinational read port. Define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, en, irq_q;
  logic [7:0]    data_q;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  state_t        state, state_n;
  logic          full, empty, push_req, push, pop, bit_end;
  logic          tx_c;
  logic [31:0]   rd_c;
  logic          unused_wd;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.we && (bus.reg_sel == 2'd0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);
  assign bit_end  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign unused_wd = ^bus.wd[31:8];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wd[7:0];
    if (pop)  data_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      en     <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (push_req && full && !pop)
        ovf <= 1'b1;
      else if (bus.we && (bus.reg_sel == 2'd1) && bus.wd[3])
        ovf <= 1'b0;
      if (bus.we && (bus.reg_sel == 2'd2)) en <= bus.wd[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      irq_q    <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + BW'(1);
      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 3'd1;
      irq_q    <= empty && (state == IDLE);
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: if (en && !empty) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: if (bit_end) state_n = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_end && bit_idx == 3'd7) state_n = PARITY;
      PARITY: if (bit_end) state_n = STOP;
`else
      DATA:   if (bit_end && bit_idx == 3'd7) state_n = STOP;
`endif
      // Chain straight into the next start bit so queued bytes leave gap-free.
      STOP: if (bit_end) begin
        if (en && !empty) begin
          pop     = 1'b1;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_c = 1'b1;
    case (state)
      START:  tx_c = 1'b0;
      DATA:   tx_c = data_q[bit_idx];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_c = even_parity(data_q);
`endif
      default: tx_c = 1'b1;
    endcase
  end

  always_comb begin
    rd_c = '0;
    case (bus.reg_sel)
      2'd1: begin
        rd_c[0]      = full;
        rd_c[1]      = empty;
        rd_c[2]      = (state != IDLE);
        rd_c[3]      = ovf;
        rd_c[4 +: CW] = count;
      end
      2'd2:    rd_c[0] = en;
      default: rd_c = '0;
    endcase
  end

  assign bus.rd  = rd_c;
  assign bus.tx  = tx_c;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed-sequence bench with random payloads; a line decoder recovers frames
// and compares them against a queue of bytes the FIFO should have accepted.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_tx_fifo_if bus();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rst_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input bit full, input bit empty, input bit busy,
                                       input bit ovf, input int count);
    return {24'b0, count[3:0], ovf, busy, empty, full};
  endfunction

  // Expected line level during bit slot k of a frame carrying byte b.
  function automatic logic exp_line(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && NB == 11) return ^b;
    return 1'b1;
  endfunction

  // Line decoder: samples mid-bit, drops any frame interrupted by reset.
  initial begin : line_mon
    logic [7:0] b;
    logic par, stp;
    int r0, c0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0 && !rst) begin
        r0 = rst_cnt;
        c0 = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.tx;
        end
        if (NB == 11) begin
          repeat (CPB) @(negedge clk);
          par = bus.tx;
        end
        repeat (CPB) @(negedge clk);
        stp = bus.tx;
        repeat (CPB - CPB / 2 - 1) @(negedge clk);
        if (rst_cnt == r0) begin
          chk("stop_bit", {31'b0, stp}, 32'd1);
          if (NB == 11) chk("parity_bit", {31'b0, par}, {31'b0, ^b});
          rx_q.push_back(b);
          rx_t.push_back(c0);
        end
      end
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [31:0] d);
    bus.we = 1'b1;
    bus.reg_sel = sel;
    bus.wd = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    bus.reg_sel = sel;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  task automatic wait_rx();
    int t;
    t = 0;
    while (rx_q.size() < exp_q.size() && t < 20 * NB * CPB) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic cmp_rx();
    wait_rx();
    repeat (2 * NB * CPB) @(negedge clk);
    chk("frame_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk("frame_byte", {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    chk("idle_tx", {31'b0, bus.tx}, 32'd1);
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  task automatic single_frame(input logic [7:0] b);
    logic etx, eirq;
    wr(2'd0, {24'b0, b});
    exp_q.push_back(b);
    for (int j = 0; j <= 4 * NB + 2; j++) begin
      etx  = (j == 0 || j > 4 * NB) ? 1'b1 : exp_line(b, (j - 1) / CPB);
      eirq = (j == 0 || j == 4 * NB + 2) ? 1'b1 : 1'b0;
      chk("tx_single", {31'b0, bus.tx}, {31'b0, etx});
      chk("irq_single", {31'b0, bus.irq}, {31'b0, eirq});
      @(negedge clk);
    end
    cmp_rx();
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b[6];
    int c_e;
    bit saw_low;
    bus.we = 1'b0;
    bus.reg_sel = 2'd0;
    bus.wd = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, bus.tx}, 32'd1);
    chk("rst_irq", {31'b0, bus.irq}, 32'd1);
    rdchk("rst_status", 2'd1, 32'h2);
    rdchk("rst_ctrl", 2'd2, 32'h1);
    rdchk("rst_txdata", 2'd0, 32'h0);
    rdchk("rst_reserved", 2'd3, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte with exact line timing
    single_frame(8'hA5);

    // Back-to-back
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    wr(2'd0, {24'b0, b[0]});
    c_e = cyc;
    wr(2'd0, {24'b0, b[1]});
    wr(2'd0, {24'b0, b[2]});
    for (int i = 0; i < 3; i++) exp_q.push_back(b[i]);
    rdchk("b2b_status", 2'd1, stat(0, 0, 1, 0, 2));
    wait_rx();
    if (rx_t.size() >= 3) begin
      chk("b2b_first_start", rx_t[0] - c_e, 32'd1);
      chk("b2b_gap01", rx_t[1] - rx_t[0], NB * CPB);
      chk("b2b_gap12", rx_t[2] - rx_t[1], NB * CPB);
    end
    cmp_rx();

    // Overflow with transmitter disabled
    wr(2'd2, 32'h0);
    rdchk("ctrl_off", 2'd2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      b[0] = 8'($urandom);
      wr(2'd0, {24'b0, b[0]});
      if (i < DEPTH) exp_q.push_back(b[0]);
    end
    repeat (10) @(negedge clk);
    chk("ovf_no_frames", rx_q.size(), 32'd0);
    chk("ovf_irq", {31'b0, bus.irq}, 32'd0);
    rdchk("ovf_status", 2'd1, stat(1, 0, 0, 1, 4));
    wr(2'd1, 32'h7);
    rdchk("ovf_keep", 2'd1, stat(1, 0, 0, 1, 4));
    wr(2'd1, 32'h8);
    rdchk("ovf_clear", 2'd1, stat(1, 0, 0, 0, 4));
    wr(2'd2, 32'h1);
    cmp_rx();
    rdchk("ovf_drained", 2'd1, stat(0, 1, 0, 0, 0));
    chk("ovf_irq_back", {31'b0, bus.irq}, 32'd1);

    // Full push/pop collision at the end of a stop bit
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    wr(2'd2, 32'h0);
    for (int i = 0; i < 4; i++) wr(2'd0, {24'b0, b[i]});
    wr(2'd2, 32'h1);
    repeat (4) @(negedge clk);
    wr(2'd0, {24'b0, b[4]});
    rdchk("coll_refill", 2'd1, stat(1, 0, 1, 0, 4));
    repeat (4 * NB - 5) @(negedge clk);
    wr(2'd0, {24'b0, b[5]});
    rdchk("coll_status", 2'd1, stat(1, 0, 1, 0, 4));
    for (int i = 0; i < 6; i++) exp_q.push_back(b[i]);
    cmp_rx();

    // Reset during data bit 3
    wr(2'd0, {24'b0, 8'($urandom)});
    wr(2'd0, {24'b0, 8'($urandom)});
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'b0, bus.tx}, 32'd1);
    rdchk("rst_mid_status", 2'd1, 32'h2);
    rst = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1) saw_low = 1'b1;
    end
    chk("rst_mid_line_idle", {31'b0, saw_low}, 32'd0);
    chk("rst_mid_no_frames", rx_q.size(), 32'd0);
    rdchk("rst_mid_status2", 2'd1, 32'h2);
    chk("rst_mid_irq", {31'b0, bus.irq}, 32'd1);

`ifdef UART_TX_PARITY_EN
    single_frame(8'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter peripheral sitting directly downstream of the memory/IO address decoder in the single-cycle core. It consumes the UART write strobe, register select and store data produced by the data path. Bytes are queued in a FIFO so the core can issue back-to-back `sb`/`sw` stores without polling per byte. Status is returned combinationally on `rd` for the load mux.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); must be ≥ 2
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2
- `clk` in 1: core clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `we` in 1: UART write strobe from the decoder, one-cycle per store
- `reg_sel` in 2: 0 = TXDATA, 1 = STATUS, 2 = CTRL, 3 = reserved (reads 0, writes ignored)
- `wd` in 32: store data from the data path
- `rd` out 32: read data to the load mux, combinational on `reg_sel`
- `tx` out 1: serial line, idle high
- `irq` out 1: high while FIFO empty and transmitter idle

## Operation
- TXDATA write: pushes `wd[7:0]` when not full. When full, the byte is dropped and sticky `ovf` is set. TXDATA reads return 0.
- STATUS read: bit0 `full`, bit1 `empty`, bit2 `busy` (FSM not IDLE), bit3 `ovf`, bits[4+C-1:4] `count` with C = log2(DEPTH)+1; other bits 0.
- STATUS write: `wd[3]`=1 clears `ovf`; other bits ignored.
- CTRL: bit0 `en`, read/write. With `en`=0 the current frame completes and no further pops occur. The FIFO still accepts writes.
- FSM states: IDLE, START, DATA, STOP (PARITY when configured).
  - IDLE→START: pop when `en` & !`empty`.
  - START→DATA: after CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
  - DATA→STOP (or PARITY→STOP).
  - STOP end: if `en` & !`empty`, pop and go directly to START; else go to IDLE.
- Simultaneous push and pop while full: both take effect, `count` unchanged, no `ovf`. Push and pop never coincide when empty, because pop decisions use registered `count`.
- Pointers wrap modulo DEPTH. `count` ranges 0..DEPTH.
- Reset values:
  - `tx`=1, `irq`=1
  - FSM IDLE, FIFO empty, `ovf`=0, `en`=1
  - `rd` reflects the selected register at those values: STATUS=0x00000002, CTRL=0x00000001
- Reset mid-frame aborts the frame: `tx` returns to 1 on the cycle after the reset edge, and queued bytes are discarded.

## Timing
- Push at edge N: `count`/`empty` update visible on `rd` in cycle N+1.
- Pop at edge N: `tx` low (start bit) from cycle N+1.
- First start bit begins 1 cycle after the push edge when idle and enabled (push at N, pop at N+1, start bit from N+2).
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity. Back-to-back frames have zero idle cycles between stop and next start.
- `irq` is registered and follows `empty` & IDLE with 1-cycle latency.
- `rd` has zero latency (combinational from `reg_sel` and registers).

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP, transmitting even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame is 11 bits.
- Not defined: 8N1 only, no PARITY state, 10-bit frame.

## Test plan
All scenarios use a bench with CLKS_PER_BIT=4 and DEPTH=4.
- Single byte: write TXDATA 0xA5 after reset.
  - `tx` sequence: 0 then 1,0,1,0,0,1,0,1 then 1, each bit 4 cycles.
  - Start bit 2 cycles after the write edge.
  - `irq` back to 1 after the stop bit.
- Back-to-back: write 0x01, 0x02, 0x03 in consecutive cycles.
  - Three frames, 120 cycles total, no idle gap.
  - STATUS `count` reads 2 after the first pop.
- Overflow: `en`=0, write 5 bytes.
  - STATUS reads `full`=1, `count`=4, `ovf`=1.
  - Write STATUS 0x8 → `ovf`=0.
  - Set `en`=1 → exactly 4 frames.
- Full push/pop collision: FIFO full, `en`=1, push on the exact pop edge at STOP end.
  - `count` stays 4, `ovf` stays 0.
  - The pushed byte is transmitted last.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - `tx`=1 the next cycle, STATUS=0x00000002.
  - No further frames.
- With `UART_TX_PARITY_EN`: byte 0x07 → parity bit 1, 44-cycle frame.
